// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder (with full_adder cell)
//  Brief    : Bit-serial WIDTH-bit adder, one full_adder evaluated per clock,
//             LSB first, carry recirculated through a register.
//  Revision : 1.0  initial release
// ============================================================================

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry_out
);

    assign sum       = a ^ b ^ cin;
    assign carry_out = (a & b) | (cin & (a ^ b));

endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out
);

    localparam int             CW     = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_s_sh;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_sum;
    logic             w_carry_out;
    logic [WIDTH-1:0] w_s_next;

    full_adder u_fa (
        .a         (r_a_sh[0]),
        .b         (r_b_sh[0]),
        .cin       (r_carry),
        .sum       (w_sum),
        .carry_out (w_carry_out)
    );

    // New sum bit enters at the MSB; written this way so WIDTH=1 needs no special case.
    assign w_s_next = WIDTH'({w_sum, r_s_sh} >> 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_s_sh  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a_sh  <= a_in;
                        r_b_sh  <= b_in;
                        r_carry <= cin_in;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_s_sh  <= w_s_next;
                    r_carry <= w_carry_out;
                    r_a_sh  <= r_a_sh >> 1;
                    r_b_sh  <= r_b_sh >> 1;
                    r_cnt   <= r_cnt + CW'(1);
                    if (r_cnt == C_LAST) begin
                        r_sum   <= w_s_next;
                        r_cout  <= w_carry_out;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign sum_out  = r_sum;
    assign cout_out = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_adder
//  Brief    : Randomized self-checking bench for serial_adder at WIDTH 8, 1, 16.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps

module tb_serial_adder;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc;

    logic        start8, c8, busy8, done8, cout8;
    logic [7:0]  a8, b8, sum8;
    logic        start1, c1, busy1, done1, cout1;
    logic [0:0]  a1, b1, sum1;
    logic        start16, c16, busy16, done16, cout16;
    logic [15:0] a16, b16, sum16;

    logic [7:0]  last8;
    logic        lastc8;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a_in(a8), .b_in(b8), .cin_in(c8),
        .busy(busy8), .done(done8), .sum_out(sum8), .cout_out(cout8)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a_in(a1), .b_in(b1), .cin_in(c1),
        .busy(busy1), .done(done1), .sum_out(sum1), .cout_out(cout1)
    );

    serial_adder #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(start16), .a_in(a16), .b_in(b16), .cin_in(c16),
        .busy(busy16), .done(done16), .sum_out(sum16), .cout_out(cout16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One 8-bit addition; expected result is plain (WIDTH+1)-bit arithmetic.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c, input bit disturb);
        logic [8:0] exp;
        exp = {1'b0, a} + {1'b0, b} + 9'(c);
        a8 = a; b8 = b; c8 = c; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        chk("busy_e0", 32'(busy8), 32'd1);
        for (int k = 1; k < 8; k++) begin
            if (disturb && (k == 3 || k == 7)) begin
                start8 = 1'b1;
                a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
            end else begin
                start8 = 1'b0;
            end
            tick();
            chk("done_early", 32'(done8), 32'd0);
            chk("busy_run", 32'(busy8), 32'd1);
            chk("sum_hold", 32'(sum8), 32'(last8));
            chk("cout_hold", 32'(cout8), 32'(lastc8));
        end
        start8 = 1'b0;
        tick();
        chk("done_e9", 32'(done8), 32'd1);
        chk("busy_e9", 32'(busy8), 32'd1);
        chk("sum8", 32'(sum8), 32'(exp[7:0]));
        chk("cout8", 32'(cout8), 32'(exp[8]));
        last8 = exp[7:0];
        lastc8 = exp[8];
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("done_after", 32'(done8), 32'd0);
            chk("busy_after", 32'(busy8), 32'd0);
            chk("sum_after", 32'(sum8), 32'(last8));
        end
    endtask

    task automatic wait_done8(output int n);
        n = 0;
        while (1) begin
            tick();
            n++;
            if (done8 === 1'b1) break;
            if (n >= 40) begin
                chk("done_timeout", 32'(done8), 32'd1);
                break;
            end
            chk("sum_stable", 32'(sum8), 32'(last8));
        end
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic c);
        logic [16:0] exp;
        exp = {1'b0, a} + {1'b0, b} + 17'(c);
        a16 = a; b16 = b; c16 = c; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        for (int k = 1; k < 16; k++) begin
            tick();
            chk("done16_early", 32'(done16), 32'd0);
        end
        tick();
        chk("done16", 32'(done16), 32'd1);
        chk("sum16", 32'(sum16), 32'(exp[15:0]));
        chk("cout16", 32'(cout16), 32'(exp[16]));
        tick();
        chk("done16_after", 32'(done16), 32'd0);
        chk("busy16_after", 32'(busy16), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] opa [3];
        logic [7:0] opb [3];
        logic       opc [3];
        logic [8:0] e;
        int         n;
        int         t_prev;
        checks = 0; errors = 0; cyc = 0;
        start8 = 0; a8 = 0; b8 = 0; c8 = 0;
        start1 = 0; a1 = 0; b1 = 0; c1 = 0;
        start16 = 0; a16 = 0; b16 = 0; c16 = 0;
        last8 = 0; lastc8 = 0;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_sum", 32'(sum8), 32'd0);
        chk("rst_cout", 32'(cout8), 32'd0);
        #3 rst = 1'b0;

        run8(8'h5A, 8'h3C, 1'b0, 1'b0);
        run8(8'hFF, 8'h01, 1'b0, 1'b0);
        run8(8'hFF, 8'hFF, 1'b1, 1'b0);
        run8(8'h10, 8'h20, 1'b0, 1'b1);
        run8(8'h5A, 8'h3C, 1'b0, 1'b0);

        // Reset mid-run must clear outputs at once and drop the operation.
        a8 = 8'hAA; b8 = 8'h55; c8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy8), 32'd0);
        chk("arst_done", 32'(done8), 32'd0);
        chk("arst_sum", 32'(sum8), 32'd0);
        chk("arst_cout", 32'(cout8), 32'd0);
        last8 = 0; lastc8 = 0;
        tick();
        tick();
        #3 rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("no_done_after_rst", 32'(done8), 32'd0);
            chk("idle_after_rst", 32'(busy8), 32'd0);
        end
        run8(8'hAA, 8'h55, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++)
            run8(8'($urandom), 8'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));

        // start held high: completions every WIDTH+2 cycles.
        for (int i = 0; i < 3; i++) begin
            opa[i] = 8'($urandom); opb[i] = 8'($urandom); opc[i] = 1'($urandom);
        end
        a8 = opa[0]; b8 = opb[0]; c8 = opc[0]; start8 = 1'b1;
        tick();
        a8 = opa[1]; b8 = opb[1]; c8 = opc[1];
        t_prev = 0;
        for (int i = 0; i < 3; i++) begin
            wait_done8(n);
            if (i == 0) chk("latency", 32'(n), 32'd8);
            else chk("interval", 32'(cyc - t_prev), 32'd10);
            t_prev = cyc;
            e = {1'b0, opa[i]} + {1'b0, opb[i]} + 9'(opc[i]);
            chk("b2b_sum", 32'(sum8), 32'(e[7:0]));
            chk("b2b_cout", 32'(cout8), 32'(e[8]));
            last8 = e[7:0]; lastc8 = e[8];
            if (i == 2) start8 = 1'b0;
            tick();
            chk("b2b_done_drop", 32'(done8), 32'd0);
            chk("b2b_busy_gap", 32'(busy8), 32'd0);
            tick();
            chk("b2b_restart", 32'(busy8), (i == 2) ? 32'd0 : 32'd1);
            if (i == 0) begin
                a8 = opa[2]; b8 = opb[2]; c8 = opc[2];
            end
        end

        // WIDTH=1: exhaustive over a, b, cin.
        for (int v = 0; v < 8; v++) begin
            a1 = 1'(v); b1 = 1'(v >> 1); c1 = 1'(v >> 2); start1 = 1'b1;
            tick();
            start1 = 1'b0;
            chk("w1_busy", 32'(busy1), 32'd1);
            chk("w1_done_early", 32'(done1), 32'd0);
            tick();
            chk("w1_done", 32'(done1), 32'd1);
            chk("w1_sum", 32'(sum1), 32'(v[0] ^ v[1] ^ v[2]));
            chk("w1_cout", 32'(cout1), 32'(((v & 1) + ((v >> 1) & 1) + ((v >> 2) & 1)) >= 2));
            tick();
            chk("w1_done_after", 32'(done1), 32'd0);
        end

        run16(16'hFFFF, 16'h0001, 1'b0);
        for (int i = 0; i < 4; i++)
            run16(16'($urandom), 16'($urandom), 1'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder built around one instance of the team's one-bit `full_adder` cell. It loads two operands and a carry-in on a start strobe. It then feeds the cell one bit pair per clock, LSB first, and registers the cell's `carry_out` back into its `cin`. After WIDTH cycles it presents the full sum and carry-out with a one-cycle done pulse. It sits between the datapath control logic (upstream, issues operands) and the `full_adder` cell (downstream, computes each bit).

## Interface
- WIDTH, 8, operand and result width in bits; legal range ≥ 1.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new addition; sampled only in IDLE.
- a_in  input  WIDTH  operand A, captured on the accepted start edge.
- b_in  input  WIDTH  operand B, captured on the accepted start edge.
- cin_in  input  1  carry-in, captured on the accepted start edge.
- busy  output  1  high whenever state ≠ IDLE.
- done  output  1  one-cycle pulse; sum_out/cout_out are valid and new.
- sum_out  output  WIDTH  registered result of the last completed addition.
- cout_out  output  1  registered carry-out of the last completed addition.

## Operation
- Internal registers:
  - a_sh and b_sh: operand shift registers, shift right, bit 0 feeds the cell.
  - s_sh: sum shift register; the cell's `sum` enters at MSB, shifts right.
  - carry: 1 bit.
  - cnt: $clog2(WIDTH+1) bits.
- Cell wiring: a=a_sh[0], b=b_sh[0], cin=carry. The cell is combinational; its outputs are consumed on the same edge.
- FSM states: IDLE, RUN, DONE.
  - IDLE: if start=1, load a_sh←a_in, b_sh←b_in, carry←cin_in, cnt←0, and go to RUN. Otherwise hold.
  - RUN: each edge:
    - s_sh←{sum, s_sh[WIDTH-1:1]}
    - carry←carry_out
    - a_sh, b_sh shift right by 1, filling with 0
    - cnt←cnt+1
  - RUN exit: on the edge where cnt==WIDTH-1, also load sum_out←{sum, s_sh[WIDTH-1:1]} and cout_out←carry_out, then go to DONE.
  - DONE: done=1 for exactly this cycle. Go to IDLE on the next edge unconditionally.
- start is ignored in RUN and DONE. No queuing: a request raised while busy must be held until IDLE.
- Arithmetic rule: {cout_out, sum_out} = a_in + b_in + cin_in, computed at (WIDTH+1)-bit width with no truncation.
- sum_out/cout_out hold their values until the next completion. They do not change during RUN.
- Reset (any time, including mid-RUN or DONE):
  - state→IDLE
  - all shift registers, carry, cnt, sum_out, cout_out→0
  - busy=0, done=0
  - an operation in flight is discarded with no done pulse.

## Timing
- Let E0 be the edge at which start=1 is sampled in IDLE.
- Edges E1…E_WIDTH process bits 0…WIDTH-1.
- busy rises after E0 and falls after E_(WIDTH+1).
- done is high between E_WIDTH and E_(WIDTH+1).
- Latency: start edge to first done-high edge sample is WIDTH+1 cycles.
- Throughput: one addition per WIDTH+2 cycles if start is held high continuously. The next E0 is the first edge in IDLE after DONE.
- done and busy are decoded from state registers only: glitch-free, with no combinational path from start.
- Reset values of all outputs are 0, taking effect asynchronously on rst assertion. The first start is accepted on the first rising edge with rst low.

## Test plan
- WIDTH=8, a_in=0x5A, b_in=0x3C, cin_in=0, 1-cycle start → done high exactly at E9 sample with sum_out=0x96, cout_out=0; busy high E1–E9.
- WIDTH=8, 0xFF+0x01, cin_in=0 → sum_out=0x00, cout_out=1. Then 0xFF+0xFF, cin_in=1 → sum_out=0xFF, cout_out=1. This checks full carry ripple through the registered loop.
- start pulses at E3 and E7 during a RUN of 0x10+0x20 → both ignored; a single done, sum_out=0x30; a_in changed after E0 does not affect the result.
- rst asserted between E4 and E5 of 0xAA+0x55 → busy, done, sum_out and cout_out go 0 immediately; no done pulse follows. A new start after release gives the correct 0xFF, cout 0.
- start held high across 3 operations with changing operands → each done exactly WIDTH+2 cycles apart. sum_out is stable between dones and matches each operand set.
- WIDTH=1 build: 1+1+cin 1 → sum_out=1, cout_out=1, done at E2. WIDTH=16: 0xFFFF+0x0001 → 0x0000, cout 1, done at E17.
